// File: rtl/demux_1to2_buf_if.sv
// Handshake bundle for demux_1to2_buf: one source stream and two destination streams.
// Counter outputs exist only when DEMUX_COUNT_EN is defined.
interface demux_1to2_buf_if #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_COUNT_EN
  logic [COUNT_W-1:0] out0_count;
  logic [COUNT_W-1:0] out1_count;
`endif

  // Demux side: consumes the source stream, produces both destination streams.
  modport slave (
    input  in_valid, in_data, sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
`ifdef DEMUX_COUNT_EN
    , output out0_count, out1_count
`endif
  );

  modport master (
    output in_valid, in_data, sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
`ifdef DEMUX_COUNT_EN
    , input out0_count, out1_count
`endif
  );
endinterface

// File: rtl/demux_1to2_buf.sv
// Registered 1:2 demux with a one-entry holding slot per output; a stalled output only blocks
// offers aimed at it. Define DEMUX_COUNT_EN to add per-output wrapping transfer counters.
module demux_1to2_buf #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input logic             clk,
  input logic             reset,
  demux_1to2_buf_if.slave bus
);

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t      slot0_state_r, slot0_state_s;
  slot_state_t      slot1_state_r, slot1_state_s;
  logic [WIDTH-1:0] slot0_data_r;
  logic [WIDTH-1:0] slot1_data_r;
  logic             in_ready_s;
  logic             load0_s, load1_s;
  logic             drain0_s, drain1_s;

  // Handshake decode: readiness depends only on the slot the source is addressing.
  always_comb begin
    in_ready_s = 1'b0;
    load0_s    = 1'b0;
    load1_s    = 1'b0;
    drain0_s   = (slot0_state_r == SLOT_FULL) && bus.out0_ready;
    drain1_s   = (slot1_state_r == SLOT_FULL) && bus.out1_ready;
    if (bus.sel) begin
      in_ready_s = (slot1_state_r == SLOT_EMPTY) || bus.out1_ready;
      load1_s    = bus.in_valid && in_ready_s;
    end else begin
      in_ready_s = (slot0_state_r == SLOT_EMPTY) || bus.out0_ready;
      load0_s    = bus.in_valid && in_ready_s;
    end
  end

  // Slot next-state: a load always wins, so drain+load in one cycle stays FULL.
  always_comb begin
    slot0_state_s = slot0_state_r;
    slot1_state_s = slot1_state_r;
    case (slot0_state_r)
      SLOT_EMPTY: if (load0_s) slot0_state_s = SLOT_FULL; else slot0_state_s = SLOT_EMPTY;
      SLOT_FULL:  if (drain0_s && !load0_s) slot0_state_s = SLOT_EMPTY; else slot0_state_s = SLOT_FULL;
      default:    slot0_state_s = SLOT_EMPTY;
    endcase
    case (slot1_state_r)
      SLOT_EMPTY: if (load1_s) slot1_state_s = SLOT_FULL; else slot1_state_s = SLOT_EMPTY;
      SLOT_FULL:  if (drain1_s && !load1_s) slot1_state_s = SLOT_EMPTY; else slot1_state_s = SLOT_FULL;
      default:    slot1_state_s = SLOT_EMPTY;
    endcase
  end

  // Slot state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_state_r <= SLOT_EMPTY;
      slot1_state_r <= SLOT_EMPTY;
    end else begin
      slot0_state_r <= slot0_state_s;
      slot1_state_r <= slot1_state_s;
    end
  end

  // Slot data: written only on load and deliberately left in place after a drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_data_r <= {WIDTH{1'b0}};
      slot1_data_r <= {WIDTH{1'b0}};
    end else begin
      if (load0_s) slot0_data_r <= bus.in_data;
      else         slot0_data_r <= slot0_data_r;
      if (load1_s) slot1_data_r <= bus.in_data;
      else         slot1_data_r <= slot1_data_r;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out0_valid = (slot0_state_r == SLOT_FULL);
  assign bus.out0_data  = slot0_data_r;
  assign bus.out1_valid = (slot1_state_r == SLOT_FULL);
  assign bus.out1_data  = slot1_data_r;

`ifdef DEMUX_COUNT_EN
  logic [COUNT_W-1:0] out0_count_r;
  logic [COUNT_W-1:0] out1_count_r;

  // Completed-transfer counters; wrap silently at the top of their range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out0_count_r <= {COUNT_W{1'b0}};
      out1_count_r <= {COUNT_W{1'b0}};
    end else begin
      if (drain0_s) out0_count_r <= out0_count_r + COUNT_W'(1'b1);
      else          out0_count_r <= out0_count_r;
      if (drain1_s) out1_count_r <= out1_count_r + COUNT_W'(1'b1);
      else          out1_count_r <= out1_count_r;
    end
  end

  assign bus.out0_count = out0_count_r;
  assign bus.out1_count = out1_count_r;
`endif

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Scoreboard bench for demux_1to2_buf: the driver queues each accepted word per port and a
// negedge monitor pops and compares on every completed output transfer.
module tb_demux_1to2_buf;

`ifdef DEMUX_COUNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  logic        hold0, hold1;
  logic [31:0] held0, held1;

  localparam logic [31:0] B2B [8] = '{32'h0000_0001, 32'h1000_0002, 32'h0000_0003, 32'h1000_0004,
                                      32'h0000_0005, 32'h1000_0006, 32'h0000_0007, 32'h1000_0008};

  demux_1to2_buf_if #(.WIDTH(32), .COUNT_W(CW)) bus ();

  demux_1to2_buf #(.WIDTH(32), .COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer one word until accepted (bounded), queue it as expected output, then drop in_valid.
  task automatic send(input logic s, input logic [31:0] d);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.sel      = s;
    bus.in_data  = d;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = bus.in_ready;
      n++;
    end
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
      @(posedge clk);
      #1;
    end else begin
      check("send_timeout", {63'd0, acc}, 64'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  // Monitor: compare every completed transfer with the scoreboard and check stall stability.
  always @(negedge clk) begin
    if (reset) begin
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if (hold0) begin
        check("out0_hold_valid", {63'd0, bus.out0_valid}, 64'd1);
        check("out0_hold_data", {32'd0, bus.out0_data}, {32'd0, held0});
      end
      if (hold1) begin
        check("out1_hold_valid", {63'd0, bus.out1_valid}, 64'd1);
        check("out1_hold_data", {32'd0, bus.out1_data}, {32'd0, held1});
      end
      if (bus.out0_valid && bus.out0_ready) begin
        if (q0.size() == 0) check("out0_unexpected", {32'd0, bus.out0_data}, 64'hDEAD);
        else check("out0_data", {32'd0, bus.out0_data}, {32'd0, q0.pop_front()});
      end
      if (bus.out1_valid && bus.out1_ready) begin
        if (q1.size() == 0) check("out1_unexpected", {32'd0, bus.out1_data}, 64'hDEAD);
        else check("out1_data", {32'd0, bus.out1_data}, {32'd0, q1.pop_front()});
      end
      hold0 = bus.out0_valid && !bus.out0_ready;
      hold1 = bus.out1_valid && !bus.out1_ready;
      held0 = bus.out0_data;
      held1 = bus.out1_data;
    end
  end

  initial begin
    int c0;
    checks = 0;
    errors = 0;
    cyc    = 0;
    hold0  = 1'b0;
    hold1  = 1'b0;
    held0  = 32'd0;
    held1  = 32'd0;
    reset  = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = 32'd0;
    bus.sel        = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    #1;
    check("rst_out0_valid", {63'd0, bus.out0_valid}, 64'd0);
    check("rst_out1_valid", {63'd0, bus.out1_valid}, 64'd0);
    check("rst_out0_data", {32'd0, bus.out0_data}, 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Routing with one-cycle latency
    send(1'b0, 32'h00AA00BB);
    check("route_out0_valid", {63'd0, bus.out0_valid}, 64'd1);
    check("route_out0_data", {32'd0, bus.out0_data}, 64'h00AA00BB);
    send(1'b1, 32'h12345678);
    check("route_out1_valid", {63'd0, bus.out1_valid}, 64'd1);
    check("route_out1_data", {32'd0, bus.out1_data}, 64'h12345678);
    @(posedge clk); #1;

    // Stall on out0 blocks only sel==0 offers
    bus.out0_ready = 1'b0;
    send(1'b0, 32'hFEDFED33);
    bus.in_valid = 1'b1;
    bus.sel      = 1'b0;
    bus.in_data  = 32'h11CCCC11;
    @(negedge clk);
    check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("stall_out0_data", {32'd0, bus.out0_data}, 64'hFEDFED33);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    c0 = cyc;
    send(1'b1, 32'h11111111);
    check("stall_other_port_cycles", 64'(cyc - c0), 64'd1);
    check("stall_out0_still", {32'd0, bus.out0_data}, 64'hFEDFED33);
    bus.out0_ready = 1'b1;
    send(1'b0, 32'h11CCCC11);
    check("stall_reload_valid", {63'd0, bus.out0_valid}, 64'd1);
    check("stall_reload_data", {32'd0, bus.out0_data}, 64'h11CCCC11);
    @(posedge clk); #1;

    // Back-to-back alternating traffic, one accept per cycle
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(B2B[i][28], B2B[i]);
    check("b2b_cycles", 64'(cyc - c0), 64'd8);
    @(posedge clk); #1;

    // Drain and fill in the same cycle keeps slot0 full
    bus.out0_ready = 1'b0;
    send(1'b0, 32'h0F0F0F0F);
    bus.out0_ready = 1'b1;
    send(1'b0, 32'hFEDCBA98);
    check("dfill_out0_valid", {63'd0, bus.out0_valid}, 64'd1);
    check("dfill_out0_data", {32'd0, bus.out0_data}, 64'hFEDCBA98);
    @(posedge clk); #1;

    // Reset mid-stream with both slots full clears everything without a clock edge
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    send(1'b0, 32'hAAAA5555);
    send(1'b1, 32'h5555AAAA);
    check("pre_rst_out0_valid", {63'd0, bus.out0_valid}, 64'd1);
    check("pre_rst_out1_valid", {63'd0, bus.out1_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out0_valid", {63'd0, bus.out0_valid}, 64'd0);
    check("async_rst_out1_valid", {63'd0, bus.out1_valid}, 64'd0);
    check("async_rst_out0_data", {32'd0, bus.out0_data}, 64'd0);
    check("async_rst_out1_data", {32'd0, bus.out1_data}, 64'd0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    bus.sel = 1'b0;
    #1 check("post_rst_in_ready_sel0", {63'd0, bus.in_ready}, 64'd1);
    bus.sel = 1'b1;
    #1 check("post_rst_in_ready_sel1", {63'd0, bus.in_ready}, 64'd1);
`ifdef DEMUX_COUNT_EN
    check("rst_out0_count", 64'(bus.out0_count), 64'd0);
    check("rst_out1_count", 64'(bus.out1_count), 64'd0);
`endif
    @(posedge clk); #1;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

`ifdef DEMUX_COUNT_EN
    // 17 out1 transfers on a 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++) send(1'b1, 32'hC000_0000 + 32'(i));
    repeat (2) @(posedge clk);
    #1;
    check("wrap_out1_count", 64'(bus.out1_count), 64'd1);
    check("wrap_out0_count", 64'(bus.out0_count), 64'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_q0_empty", 64'(q0.size()), 64'd0);
    check("sb_q1_empty", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
